// File: rtl/priority_encoder_seq.sv
// Sequential 16-to-4 priority encoder: sticky pending register, lowest index offered
// over a valid/ready handshake and retired on acceptance, plus a saturating merge counter.
module priority_encoder_seq #(
    parameter int N_IN   = 16,
    parameter int CODE_W = $clog2(N_IN),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [N_IN-1:0]   req_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic [N_IN-1:0]   pending_out,
    output logic [CNT_W-1:0]  merge_cnt,
    input  logic              merge_clr
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OFFER = 1'b1;

    // Wide enough to hold the counter plus a full-width popcount without overflow.
    localparam int               SUM_W   = CNT_W + CODE_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [0:0]       state;
    logic             accept;
    logic [N_IN-1:0]  accept_mask;
    logic [N_IN-1:0]  remaining;
    logic [N_IN-1:0]  capture;
    logic [N_IN-1:0]  pending_next;
    logic [SUM_W-1:0] merge_hits;
    logic [SUM_W-1:0] merge_sum;

    function automatic logic [CODE_W-1:0] lowest_index(input logic [N_IN-1:0] v);
        lowest_index = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_index = CODE_W'(i);
            end
        end
    endfunction

    assign code_valid = (state == OFFER);

    // Accepted bit is cleared before capture is ORed in, so a same-cycle re-request wins.
    always_comb begin
        accept       = (state == OFFER) && code_ready;
        accept_mask  = accept ? (N_IN'(1) << code_out) : '0;
        remaining    = pending_out & ~accept_mask;
        capture      = enable ? req_in : '0;
        pending_next = remaining | capture;
        merge_hits   = '0;
        for (int i = 0; i < N_IN; i++) begin
            merge_hits = merge_hits + SUM_W'(capture[i] & remaining[i]);
        end
        merge_sum = SUM_W'(merge_cnt) + merge_hits;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            code_out    <= '0;
            pending_out <= '0;
            merge_cnt   <= '0;
        end else begin
            pending_out <= pending_next;

            if (merge_clr) begin
                merge_cnt <= '0;
            end else if (merge_sum > CNT_MAX) begin
                merge_cnt <= '1;
            end else begin
                merge_cnt <= merge_sum[CNT_W-1:0];
            end

            // An un-accepted offer is held; otherwise pick the next index from the
            // registered pending bits (minus any bit retired at this edge).
            if (state == IDLE || accept) begin
                if (enable && remaining != '0) begin
                    state    <= OFFER;
                    code_out <= lowest_index(remaining);
                end else begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Scoreboard bench for priority_encoder_seq: directed scenarios plus randomized traffic
// checked against a set-based reference model of pending requests and the offered code.
module tb_priority_encoder_seq;

    localparam int N_IN   = 16;
    localparam int CODE_W = 4;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [N_IN-1:0]   req_in = '0;
    logic [CODE_W-1:0] code_out;
    logic              code_valid;
    logic              code_ready = 1'b0;
    logic [N_IN-1:0]   pending_out;
    logic [CNT_W-1:0]  merge_cnt;
    logic              merge_clr = 1'b0;

    priority_encoder_seq #(.N_IN(N_IN), .CODE_W(CODE_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req_in     (req_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .pending_out(pending_out),
        .merge_cnt  (merge_cnt),
        .merge_clr  (merge_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_IN-1:0]   pend;
        logic              valid;
        logic [CODE_W-1:0] code;
        logic [CNT_W-1:0]  merge;
    } snap_t;

    snap_t             snap_q[$];
    logic [CODE_W-1:0] code_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the set of pending requests, the offered code and a merge tally.
    logic [N_IN-1:0] m_pend  = '0;
    bit              m_offer = 1'b0;
    int              m_code  = 0;
    int              m_merge = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_idx(input logic [N_IN-1:0] v);
        for (int i = 0; i < N_IN; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic push_snapshot();
        snap_t s;
        s.pend  = m_pend;
        s.valid = m_offer;
        s.code  = CODE_W'(m_code);
        s.merge = CNT_W'(m_merge);
        snap_q.push_back(s);
    endtask

    task automatic model_step(input bit en, input logic [N_IN-1:0] req, input bit rdy, input bit clr);
        logic [N_IN-1:0] left;
        int              hits;
        bit              taken;
        taken = m_offer && rdy;
        left  = m_pend;
        if (taken) left[m_code] = 1'b0;
        hits = 0;
        if (en) begin
            for (int i = 0; i < N_IN; i++) begin
                if (req[i] && left[i]) hits++;
            end
        end
        if (!m_offer || taken) begin
            if (en && left != '0) begin
                m_offer = 1'b1;
                m_code  = lowest_idx(left);
            end else begin
                m_offer = 1'b0;
            end
        end
        m_pend  = en ? (left | req) : left;
        m_merge = clr ? 0 : ((m_merge + hits > 255) ? 255 : m_merge + hits);
    endtask

    task automatic applyStimulus(input bit en, input logic [N_IN-1:0] req, input bit rdy, input bit clr);
        @(negedge clk);
        #1;
        rst_n      = 1'b1;
        enable     = en;
        req_in     = req;
        code_ready = rdy;
        merge_clr  = clr;
        push_snapshot();
        if (m_offer && rdy) code_q.push_back(CODE_W'(m_code));
        model_step(en, req, rdy, clr);
    endtask

    task automatic resetDut();
        @(negedge clk);
        #1;
        rst_n      = 1'b0;
        enable     = 1'b0;
        req_in     = '0;
        code_ready = 1'b0;
        merge_clr  = 1'b0;
        #1;
        checkOutput("async_rst_valid", code_valid, 0);
        checkOutput("async_rst_pending", pending_out, 0);
        checkOutput("async_rst_merge", merge_cnt, 0);
        checkOutput("async_rst_code", code_out, 0);
        m_pend  = '0;
        m_offer = 1'b0;
        m_code  = 0;
        m_merge = 0;
        push_snapshot();
    endtask

    // Monitor: compares settled DUT state with the model snapshot and retires handshakes.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            #3;
            if (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                checkOutput("pending_out", pending_out, s.pend);
                checkOutput("code_valid", code_valid, s.valid);
                checkOutput("code_out", code_out, s.code);
                checkOutput("merge_cnt", merge_cnt, s.merge);
            end
            if (code_valid && code_ready) begin
                if (code_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_handshake: got code 0x%0h expected no offer at %0t",
                             code_out, $time);
                end else begin
                    checkOutput("handshake_code", code_out, code_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [N_IN-1:0] r;
        $display("[TB] starting priority_encoder_seq bench");

        resetDut();
        for (int i = 0; i < 10; i++) applyStimulus(1, '0, 0, 0);

        applyStimulus(1, 16'h0020, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, '0, 1, 0);

        applyStimulus(1, 16'h8101, 1, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, '0, 1, 0);

        applyStimulus(1, 16'h0010, 0, 0);
        applyStimulus(1, '0, 0, 0);
        applyStimulus(1, 16'h0001, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, '0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, '0, 1, 0);

        applyStimulus(1, 16'h0008, 0, 0);
        applyStimulus(1, '0, 0, 0);
        applyStimulus(1, 16'h0008, 1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, '0, 1, 0);
        applyStimulus(1, 16'h0001, 0, 0);
        applyStimulus(1, 16'h0003, 0, 0);
        applyStimulus(1, 16'h0003, 0, 0);
        applyStimulus(1, '0, 0, 0);
        checkOutput("merge_three", merge_cnt, 3);
        applyStimulus(1, '0, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, '0, 1, 0);

        applyStimulus(1, 16'h0004, 0, 0);
        applyStimulus(1, '0, 0, 0);
        applyStimulus(0, 16'hFFFF, 0, 0);
        applyStimulus(0, 16'hFFFF, 1, 0);
        applyStimulus(0, '0, 0, 0);
        applyStimulus(1, 16'h0002, 0, 0);
        applyStimulus(1, '0, 0, 0);
        applyStimulus(1, '0, 0, 0);
        checkOutput("pre_reset_valid", code_valid, m_offer);
        resetDut();
        applyStimulus(1, '0, 0, 0);

        for (int i = 0; i < 20; i++) applyStimulus(1, 16'hFFFF, 0, 0);
        applyStimulus(1, 16'hFFFF, 0, 0);
        applyStimulus(1, 16'hFFFF, 0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(1, '0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 2) == 0) ? N_IN'($urandom & $urandom & $urandom) : '0;
            applyStimulus($urandom_range(0, 9) != 0, r, $urandom_range(0, 9) < 7,
                          $urandom_range(0, 19) == 0);
        end
        for (int i = 0; i < 20; i++) applyStimulus(1, '0, 1, 0);

        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(1, '0, 1, 0);
        @(negedge clk);
        @(negedge clk);
        #5;
        checkOutput("code_queue_drained", code_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_encoder_seq.md
Name: priority_encoder_seq

Overview:
- Sequential 16-to-4 priority encoder; the inverse of the team's 4-to-16 binary decoder.
- Captures request pulses or levels on 16 lines into a sticky pending register.
- Presents the highest-priority pending index as a binary code over a valid/ready handshake and retires each index on acceptance.
- Sits between interrupt/event sources and a consumer that re-expands codes with the decoder. Bit 0 corresponds to code 4'h0, bit 15 to 4'hF.

Parameters:
- N_IN, 16, number of request lines (power of two, 2..64).
- CODE_W, $clog2(N_IN) = 4, width of code_out.
- CNT_W, 8, width of the saturating merge counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = capture requests and issue new codes; 0 = freeze capture and issue.
- req_in  input  N_IN  request lines, sampled every clk when enable=1.
- code_out  output  CODE_W  index of the offered request.
- code_valid  output  1  code_out holds an offered index.
- code_ready  input  1  consumer accepts code_out when high together with code_valid.
- pending_out  output  N_IN  current pending register.
- merge_cnt  output  CNT_W  count of requests that hit an already-pending bit.
- merge_clr  input  1  synchronous clear of merge_cnt.

Behaviour:
- Reset (rst_n=0, async): pending_out=0, code_out=0, code_valid=0, merge_cnt=0, FSM=IDLE. Reset mid-offer drops the offer and all pending bits immediately.
- Priority: lowest set index wins (bit 0 highest), selected from the pending register only, never directly from req_in.
- Capture: when enable=1, each clk sets pending[i] |= req_in[i]. A request lands in pending_out one cycle after it is sampled.
- FSM states:
  - IDLE: code_valid=0. If enable=1 and pending!=0 → OFFER, loading code_out with the priority index of pending (the registered value, before this cycle's capture).
  - OFFER: code_valid=1. code_out and code_valid stay stable until accepted, even if a higher-priority request arrives, enable drops, or merge_clr asserts. No retraction.
- Accept (code_valid & code_ready in OFFER):
  - pending[code_out] is cleared at that edge.
  - If enable=1 and (pending with the accepted bit cleared) != 0, stay in OFFER and load the next index at the same edge (back-to-back, no bubble). Otherwise → IDLE.
- Latency: req_in sampled at edge N → pending at N → code_valid=1 at N+1 when idle. Throughput is one code per cycle with code_ready held high.
- Simultaneous set/clear: if req_in[k]=1 and bit k is accepted in the same cycle, the set wins and pending[k] stays 1. This re-request is not a merge.
- Merge:
  - A sampled req_in[i]=1 while pending[i] is already 1 (and not being cleared that cycle) increments merge_cnt by 1 for each such bit, i.e. a popcount.
  - merge_cnt saturates at 2^CNT_W-1.
  - merge_clr=1 forces merge_cnt=0 and has priority over increments in the same cycle.
- enable=0: no capture, no merge counting, no transition IDLE→OFFER. An in-flight offer still completes on code_ready, then the FSM goes to IDLE.
- Wrap-around: none. Pending bits are independent; an empty pending register in IDLE yields code_valid=0 and code_out holds its last value.

Test Plan:
- Reset/empty: rst_n low then high, req_in=0 for 10 cycles → code_valid=0, pending_out=0, merge_cnt=0 throughout.
- Single request: pulse req_in=16'h0020 for 1 cycle, code_ready=1 → pending_out=16'h0020 next cycle, code_valid=1 with code_out=4'h5 the cycle after for exactly 1 cycle, then pending_out=0.
- Priority and back-to-back: pulse req_in=16'h8101, code_ready=1 → code_out sequence 4'h0, 4'h8, 4'hF on consecutive cycles, then code_valid=0.
- Stability under backpressure: pending=16'h0010 offered (code_out=4'h4), code_ready=0; pulse req_in=16'h0001 → code_out stays 4'h4 until code_ready=1, then 4'h0 is offered next.
- Merge and set-wins: with bit 3 pending and offered, drive req_in=16'h0008 on the accept cycle → pending_out[3] stays 1, merge_cnt unchanged. Drive req_in=16'h0003 twice with code_ready=0 and pending=16'h0001 → merge_cnt=3 (1 from the first pulse, 2 from the second). Assert merge_clr → merge_cnt=0.
- enable/reset mid-operation: code offered, enable=0, pulse req_in=16'hFFFF → no capture, offer completes on code_ready, then code_valid=0. Assert rst_n=0 while code_valid=1 → code_valid=0 and pending_out=0 without waiting for clk.
